// File: rtl/btb_assoc.sv
// rtl/btb_assoc.sv - tagged set-associative branch target buffer, optional write-forward under BTB_BYPASS_EN
module btb_assoc #(
    parameter int S_INDEX = 6,
    parameter int WAYS    = 2,
    parameter int TAG_W   = 30 - S_INDEX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall,
    input  logic [31:0] pc_out,
    input  logic        load_btb,
    input  logic [31:0] idex_pc_value,
    input  logic [31:0] target_addr,
    output logic        btb_hit,
    output logic [31:0] btb_out
);
    localparam int SETS  = 2 ** S_INDEX;
    localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [SETS-1:0][WAYS-1:0] valid;
    logic [TAG_W-1:0]          tag_mem    [SETS][WAYS];
    logic [31:0]               target_mem [SETS][WAYS];
    logic [PTR_W-1:0]          ptr        [SETS];

    logic [S_INDEX-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;

    assign lk_idx = pc_out[S_INDEX+1:2];
    assign lk_tag = pc_out[31:S_INDEX+2];
    assign up_idx = idex_pc_value[S_INDEX+1:2];
    assign up_tag = idex_pc_value[31:S_INDEX+2];

    // Byte-offset bits never participate in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_out[1:0], idex_pc_value[1:0]};

    logic [WAYS-1:0] lk_match;
    logic            lk_hit;
    logic [31:0]     lk_target;

    // Lookup: tag compare across all ways of the fetch set; at most one way can match.
    always_comb begin
        lk_match  = '0;
        lk_hit    = 1'b0;
        lk_target = 32'h0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[lk_idx][w] && (tag_mem[lk_idx][w] == lk_tag)) begin
                lk_match[w] = 1'b1;
                lk_hit      = 1'b1;
                lk_target   = lk_target | target_mem[lk_idx][w];
            end
        end
`ifdef BTB_BYPASS_EN
        if (load_btb && !flush && (up_idx == lk_idx) && (up_tag == lk_tag)) begin
            lk_hit    = 1'b1;
            lk_target = target_addr;
        end
`endif
    end

    logic             up_hit, up_free, up_evict;
    logic [PTR_W-1:0] up_hit_way, up_free_way, up_way, ptr_next;

    // Victim selection: matching way first, then lowest invalid way, else round-robin pointer.
    always_comb begin
        up_hit      = 1'b0;
        up_free     = 1'b0;
        up_hit_way  = '0;
        up_free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[up_idx][w] && (tag_mem[up_idx][w] == up_tag)) begin
                up_hit     = 1'b1;
                up_hit_way = PTR_W'(w);
            end
            if (!valid[up_idx][w]) begin
                up_free     = 1'b1;
                up_free_way = PTR_W'(w);
            end
        end
        up_evict = !up_hit && !up_free;
        up_way   = up_hit ? up_hit_way : (up_free ? up_free_way : ptr[up_idx]);
        ptr_next = (ptr[up_idx] == PTR_W'(WAYS - 1)) ? '0 : ptr[up_idx] + PTR_W'(1);
    end

    // Valid bits and replacement pointers; flush clears valids but leaves pointers alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            for (int s = 0; s < SETS; s++) ptr[s] <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (load_btb) begin
            valid[up_idx][up_way] <= 1'b1;
            if (up_evict) ptr[up_idx] <= ptr_next;
        end
    end

    // Tag and target payload; content is qualified by valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (load_btb && !flush && !rst) begin
            tag_mem[up_idx][up_way]    <= up_tag;
            target_mem[up_idx][up_way] <= target_addr;
        end
    end

    // Registered lookup result; flush zeroes it even while stalled.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            btb_hit <= 1'b0;
            btb_out <= 32'h0;
        end else if (!stall) begin
            btb_hit <= lk_hit;
            btb_out <= lk_target;
        end
    end

    // Update-in-place keeps tags unique within a set.
    always_ff @(posedge clk) begin
        if (!rst) assert ($onehot0(lk_match));
    end
endmodule
